// File: rtl/fb_pixel_writer_if.sv
// Pixel stream, clear control and framebuffer write port of the pixel writer.
// The master side drives pixels, clear requests and the arbiter grant.
interface fb_pixel_writer_if;
    logic        plot;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot_ready;
    logic        clear_req;
    logic        clear_busy;
    logic        fb_grant;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_wdata;
    logic [15:0] clip_count;

    modport master (
        output plot, x, y, colour, clear_req, fb_grant,
        input  plot_ready, clear_busy, fb_we, fb_addr, fb_wdata, clip_count
    );

    modport slave (
        input  plot, x, y, colour, clear_req, fb_grant,
        output plot_ready, clear_busy, fb_we, fb_addr, fb_wdata, clip_count
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// Pixel stream sink: clips, buffers and writes pixels into the framebuffer,
// plus a full-screen clear engine.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no write request; picks a clear (priority) or the pixel FIFO
//   S_DRAIN | presenting FIFO head on the write port until the FIFO empties
//   S_CLEAR | walking clr_cnt over every address with BG_COLOUR
module fb_pixel_writer #(
    parameter int unsigned H_RES      = 160,
    parameter int unsigned V_RES      = 120,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    fb_pixel_writer_if.slave  bus
);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  X_LIM     = 8'(H_RES);
    localparam logic [7:0]  Y_LIM     = 8'(V_RES);
    localparam logic [14:0] LAST_ADDR = 15'(H_RES * V_RES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]       state;
    logic [14:0]      clr_cnt;
    logic             clear_pending;

    logic [17:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [17:0]      head;

    logic             in_range;
    logic             accept;
    logic             push;
    logic             clip;
    logic             pop;
    logic [14:0]      pix_addr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    assign in_range = (bus.x < X_LIM) && (bus.y < Y_LIM);
    assign accept   = bus.plot && !fifo_full;
    assign push     = accept && in_range;
    assign clip     = accept && !in_range;
    assign pop      = (state == S_DRAIN) && bus.fb_grant;

    // y*160 as two shifts; y < 120 keeps the sum inside 15 bits.
    assign pix_addr = ({7'd0, bus.y} << 7) + ({7'd0, bus.y} << 5) + {7'd0, bus.x};

    assign bus.plot_ready = !fifo_full;
    assign bus.clear_busy = (state == S_CLEAR) || clear_pending;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {pix_addr, bus.colour};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            bus.clip_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            if (clip && (bus.clip_count != 16'hFFFF)) begin
                bus.clip_count <= bus.clip_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            clr_cnt       <= '0;
            clear_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.clear_req || clear_pending) begin
                        state         <= S_CLEAR;
                        clr_cnt       <= '0;
                        clear_pending <= 1'b0;
                    end else if (!fifo_empty) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // A clear arriving mid-drain waits until the queued pixels are out.
                    if (bus.clear_req) begin
                        clear_pending <= 1'b1;
                    end
                    if (pop && !push && (fifo_count == (PTR_W+1)'(1))) begin
                        state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (bus.fb_grant) begin
                        if (clr_cnt == LAST_ADDR) begin
                            state <= S_IDLE;
                        end else begin
                            clr_cnt <= clr_cnt + 15'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.fb_we    = 1'b0;
        bus.fb_addr  = '0;
        bus.fb_wdata = '0;
        case (state)
            S_DRAIN: begin
                bus.fb_we    = 1'b1;
                bus.fb_addr  = head[17:3];
                bus.fb_wdata = head[2:0];
            end
            S_CLEAR: begin
                bus.fb_we    = 1'b1;
                bus.fb_addr  = clr_cnt;
                bus.fb_wdata = BG_COLOUR;
            end
            default: ;
        endcase
    end
endmodule
